// File: rtl/fpu_sqrt_ctrl_pkg.sv
// Shared definitions for the restoring square-root controller:
// state encoding, default sizing and result-mux select codes.
package fpu_sqrt_pkg;

    localparam int unsigned ITER_DEF  = 24;
    localparam int unsigned CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ITER   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    typedef enum logic {
        OUT_ROOT    = 1'b0,
        OUT_SPECIAL = 1'b1
    } out_sel_t;

endpackage

// File: rtl/fpu_sqrt_ctrl_if.sv
// Handshake and datapath-control bundle between the FPU top/datapath
// (master) and the square-root controller (slave).
interface fpu_sqrt_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    logic             start;
    logic             byp;
    logic             abort;
    logic             rem_neg;
    logic             busy;
    logic             init_sel;
    logic             ld_rad;
    logic             ld_rem;
    logic             ld_root;
    logic             rem_sel;
    logic             q_bit;
    logic [CNT_W-1:0] iter_idx;
    logic             ld_out;
    logic             out_sel;
    logic             done;

    modport master (
        output start, byp, abort, rem_neg,
        input  busy, init_sel, ld_rad, ld_rem, ld_root, rem_sel, q_bit,
               iter_idx, ld_out, out_sel, done
    );

    modport slave (
        input  start, byp, abort, rem_neg,
        output busy, init_sel, ld_rad, ld_rem, ld_root, rem_sel, q_bit,
               iter_idx, ld_out, out_sel, done
    );
endinterface

// File: rtl/fpu_sqrt_ctrl_iter_cnt.sv
// Iteration counter for the sqrt controller: clear has priority over
// enable; tc flags the last root-digit iteration.
module sqrt_iter_cnt
    import fpu_sqrt_pkg::*;
#(
    parameter int unsigned ITER  = ITER_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(ITER - 1));

endmodule

// File: rtl/fpu_sqrt_ctrl.sv
// Control FSM for the multi-cycle restoring square-root datapath:
// LOAD, ITER root-digit steps (or a bypass straight to FINISH), done pulse.
module fpu_sqrt_ctrl
    import fpu_sqrt_pkg::*;
#(
    parameter int unsigned ITER  = ITER_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fpu_sqrt_ctrl_if.slave    bus
);

    state_t           state_q, state_d;
    logic             byp_q, byp_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] count;
    out_sel_t         out_sel;

    sqrt_iter_cnt #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byp_d        = byp_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        out_sel      = OUT_ROOT;
        bus.busy     = 1'b0;
        bus.init_sel = 1'b0;
        bus.ld_rad   = 1'b0;
        bus.ld_rem   = 1'b0;
        bus.ld_root  = 1'b0;
        bus.rem_sel  = 1'b0;
        bus.q_bit    = 1'b0;
        bus.ld_out   = 1'b0;
        bus.done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                // abort outranks a simultaneous start
                if (bus.start && !bus.abort) begin
                    byp_d   = bus.byp;
                    state_d = bus.byp ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                bus.busy = 1'b1;
                cnt_clr  = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                    byp_d   = 1'b0;
                end else begin
                    bus.init_sel = 1'b1;
                    bus.ld_rad   = 1'b1;
                    bus.ld_rem   = 1'b1;
                    bus.ld_root  = 1'b1;
                    state_d      = S_ITER;
                end
            end
            S_ITER: begin
                bus.busy    = 1'b1;
                bus.q_bit   = ~bus.rem_neg;
                bus.rem_sel = ~bus.rem_neg;
                if (bus.abort) begin
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                    byp_d   = 1'b0;
                end else begin
                    bus.ld_rad  = 1'b1;
                    bus.ld_rem  = 1'b1;
                    bus.ld_root = 1'b1;
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                bus.busy = 1'b1;
                out_sel  = byp_q ? OUT_SPECIAL : OUT_ROOT;
                cnt_clr  = 1'b1;
                state_d  = S_IDLE;
                byp_d    = 1'b0;
                if (!bus.abort) begin
                    bus.ld_out = 1'b1;
                    bus.done   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                byp_d   = 1'b0;
            end
        endcase
    end

    assign bus.out_sel  = out_sel;
    assign bus.iter_idx = count;

endmodule

// File: tb/tb_fpu_sqrt_ctrl.sv
// Directed self-checking bench for fpu_sqrt_ctrl: normal, bypass,
// ignored starts, abort and asynchronous reset scenarios.
module tb_fpu_sqrt_ctrl;
    import fpu_sqrt_pkg::*;

    localparam int unsigned ITER  = 24;
    localparam int unsigned CNT_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    fpu_sqrt_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fpu_sqrt_ctrl #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [14:0] mk(input logic b, input logic init, input logic rad,
                                       input logic rem, input logic root, input logic rsel,
                                       input logic q, input logic lo, input logic os,
                                       input logic dn, input logic [4:0] idx);
        return {b, init, rad, rem, root, rsel, q, lo, os, dn, idx};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.busy, bus.init_sel, bus.ld_rad, bus.ld_rem, bus.ld_root, bus.rem_sel,
                bus.q_bit, bus.ld_out, bus.out_sel, bus.done, bus.iter_idx};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.byp     = 1'b0;
        bus.abort   = 1'b0;
        bus.rem_neg = 1'b0;
    endtask

    // Full normal operation starting from IDLE; noise pulses start/byp while busy.
    task automatic run_op(input string tag, input bit noise);
        logic [14:0] e;
        logic        rn;
        logic [4:0]  idx;
        clear_inputs();
        bus.start = 1'b1;
        #1;
        compared++;
        if (obs() !== 15'h0) begin
            mismatched++;
            $display("FAIL %s cycle 0: got %h want %h", tag, obs(), 15'h0);
        end
        for (int c = 1; c <= int'(ITER) + 4; c++) begin
            next_cycle();
            clear_inputs();
            rn  = 1'b0;
            idx = 5'(c - 2);
            if (c >= 2 && c <= int'(ITER) + 1) rn = pat[(c - 2) % 5];
            bus.rem_neg = rn;
            if (noise && (c == 7 || c == int'(ITER) + 2)) begin
                bus.start = 1'b1;
                bus.byp   = 1'b1;
            end
            #1;
            if (c == 1)                     e = mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 5'd0);
            else if (c <= int'(ITER) + 1)   e = mk(1, 0, 1, 1, 1, !rn, !rn, 0, 0, 0, idx);
            else if (c == int'(ITER) + 2)   e = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'd0);
            else                            e = 15'h0;
            compared++;
            if (obs() !== e) begin
                mismatched++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, c, obs(), e);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        compared++;
        if (obs() !== 15'h0) begin
            mismatched++;
            $display("FAIL reset_async: got %h want %h", obs(), 15'h0);
        end
        next_cycle();
        next_cycle();
        compared++;
        if (obs() !== 15'h0) begin
            mismatched++;
            $display("FAIL reset_held: got %h want %h", obs(), 15'h0);
        end
        rst = 1'b0;
        next_cycle();
        compared++;
        if (obs() !== 15'h0) begin
            mismatched++;
            $display("FAIL reset_idle: got %h want %h", obs(), 15'h0);
        end
    endtask

    task automatic test_normal();
        run_op("normal", 1'b0);
    endtask

    task automatic test_bypass();
        clear_inputs();
        bus.start = 1'b1;
        bus.byp   = 1'b1;
        next_cycle();
        clear_inputs();
        #1;
        compared++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'd0)) begin
            mismatched++;
            $display("FAIL bypass_finish: got %h want %h", obs(),
                     mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'd0));
        end
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            compared++;
            if (obs() !== 15'h0) begin
                mismatched++;
                $display("FAIL bypass_idle cycle %0d: got %h want %h", c, obs(), 15'h0);
            end
        end
    endtask

    task automatic test_busy_start();
        run_op("busy_start", 1'b1);
    endtask

    task automatic test_abort();
        clear_inputs();
        bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            clear_inputs();
        end
        next_cycle();
        bus.abort   = 1'b1;
        bus.rem_neg = 1'b1;
        #1;
        compared++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7)) begin
            mismatched++;
            $display("FAIL abort_cycle: got %h want %h", obs(),
                     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7));
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            clear_inputs();
            #1;
            compared++;
            if (obs() !== 15'h0) begin
                mismatched++;
                $display("FAIL abort_after cycle %0d: got %h want %h", c, obs(), 15'h0);
            end
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        next_cycle();
        clear_inputs();
        for (int c = 1; c <= 2; c++) begin
            compared++;
            if (obs() !== 15'h0) begin
                mismatched++;
                $display("FAIL abort_start_idle cycle %0d: got %h want %h", c, obs(), 15'h0);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        bus.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            clear_inputs();
        end
        compared++;
        if (bus.iter_idx !== 5'd10) begin
            mismatched++;
            $display("FAIL reset_mid_position: got %0d want %0d", bus.iter_idx, 10);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (obs() !== 15'h0) begin
            mismatched++;
            $display("FAIL reset_mid_async: got %h want %h", obs(), 15'h0);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            compared++;
            if (obs() !== 15'h0) begin
                mismatched++;
                $display("FAIL reset_mid_idle cycle %0d: got %h want %h", c, obs(), 15'h0);
            end
        end
        run_op("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bypass();
        test_busy_start();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_sqrt_ctrl.md
Name: fpu_sqrt_ctrl

Overview:
- Control unit for the FPU's multi-cycle restoring square-root datapath.
- Sequences load-enable and select signals for the radicand, remainder, root and result registers; those registers are simple load-enable registers.
- Accepts a start/byp request from the FPU top, runs ITER root-digit iterations (or a special-case bypass), then pulses done.
- Datapath arithmetic is outside this block; only the trial-remainder sign flag comes back in.

Parameters:
- ITER, 24, number of root bits produced (one per ITER-state cycle); legal range 2..2^CNT_W.
- CNT_W, 5, width of the iteration counter and iter_idx.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request a new sqrt; sampled only in IDLE
- byp  in  1  special operand (zero/inf/NaN/negative) flagged by unpacker; sampled with start
- abort  in  1  synchronous cancel of the current operation
- rem_neg  in  1  sign of the current trial remainder from the datapath
- busy  out  1  high in every state except IDLE
- init_sel  out  1  registers load initial values (radicand in, remainder 0, root 0)
- ld_rad  out  1  radicand register load (shift by 2 in ITER)
- ld_rem  out  1  remainder register load
- ld_root  out  1  root register load (shift left, q_bit in)
- rem_sel  out  1  1 = take trial remainder, 0 = restore (keep shifted old remainder)
- q_bit  out  1  root bit shifted in this iteration
- iter_idx  out  CNT_W  current iteration number, 0..ITER-1
- ld_out  out  1  result register load
- out_sel  out  1  1 = result mux selects the special-value path, 0 = computed root
- done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, ITER, FINISH. The state register and counter reset asynchronously to IDLE and 0.
- Reset values: every output is 0 and iter_idx is 0.
- Reset mid-operation: return to IDLE immediately; no done is issued.
- IDLE:
  - busy=0 and all enables are 0.
  - start=1, byp=0 → LOAD.
  - start=1, byp=1 → FINISH with the bypass flag set.
  - start=0 → stay in IDLE.
- LOAD (1 cycle):
  - init_sel=1, ld_rad=ld_rem=ld_root=1.
  - Counter cleared to 0; → ITER.
- ITER (exactly ITER cycles):
  - ld_rad=ld_rem=ld_root=1.
  - q_bit=~rem_neg and rem_sel=~rem_neg, combinational from rem_neg in the same cycle.
  - Counter increments each cycle; iter_idx shows the counter value.
  - When counter==ITER-1 → FINISH and the counter clears.
- FINISH (1 cycle):
  - ld_out=1, done=1, busy=1.
  - out_sel=1 if the bypass flag is set, else 0.
  - → IDLE; the bypass flag clears.
- Latency, with start sampled at the end of cycle 0:
  - Normal path: done is high in cycle ITER+2 (cycle 26 at the default). Total occupancy is ITER+2 cycles.
  - Bypass path: done is high in cycle 1.
- start while busy, including the FINISH cycle: ignored, with no queueing. The requester must re-assert start in IDLE.
- byp is ignored unless start is accepted.
- abort, in any non-IDLE state:
  - All load enables, ld_out and done are forced to 0 in that cycle.
  - Next state is IDLE; counter and bypass flag clear.
  - abort in IDLE is a no-op. abort together with start in IDLE: abort wins and start is dropped.
- Outputs are decoded from state, except q_bit and rem_sel, which are Mealy on rem_neg. They are glitch-tolerant because they are consumed only at the clock edge.
- Counter is CNT_W bits with no wrap: the comparison with ITER-1 ends the phase before overflow.

Decomposition:
- Shared package fpu_sqrt_pkg holds:
  - the state encoding (IDLE=0, LOAD=1, ITER=2, FINISH=3, 2-bit);
  - the default ITER/CNT_W constants;
  - the out_sel codes.
- One natural sub-module, sqrt_iter_cnt: CNT_W-bit counter with clear, enable and a terminal-count flag (count==ITER-1).
- The FSM instantiates sqrt_iter_cnt and holds the next-state and output decode.

Test Plan:
- Reset asserted mid-ITER (iter_idx=10) → all outputs 0 asynchronously, state IDLE, no done; a later start runs the full 26 cycles.
- start=1, byp=0, ITER=24:
  - LOAD in cycle 1 with init_sel=1;
  - ITER in cycles 2..25 with iter_idx 0..23;
  - done=ld_out=1 only in cycle 26, out_sel=0;
  - busy high in cycles 1..26.
- Drive rem_neg pattern 1,0,1,1,0… during ITER → q_bit/rem_sel equal 0,1,0,0,1… in the same cycles.
- start=1, byp=1 → FINISH in cycle 1 with done=ld_out=out_sel=1; no ld_rad/ld_rem/ld_root ever asserted.
- start pulsed at iter_idx=5 and again in the FINISH cycle → both ignored; busy falls after done and no second operation starts.
- abort at iter_idx=7 → enables 0 that cycle, IDLE next cycle, no done; abort+start together in IDLE → stays in IDLE.
